// File: rtl/output_uart_bridge.sv
// Buffers core output strobes in a FIFO and transmits each as an ASCII line
// "II:DDDD\r\n" on an 8N1 UART pin.
module output_uart_bridge #(
    parameter int NUM_CORES    = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         output_enable,
    input  logic [$clog2(NUM_CORES)-1:0] output_core_id,
    input  logic [15:0]                  output_data_val,
    output logic                         uart_tx,
    output logic                         overflow,
    output logic                         busy
);

    localparam int ID_W    = $clog2(NUM_CORES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CLK_W   = $clog2(CLKS_PER_BIT);
    localparam int ENTRY_W = ID_W + 16;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_next;
    logic               push, pop, fifo_full;

    state_t             state, state_next;
    logic [CLK_W-1:0]   clk_cnt, clk_cnt_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic [3:0]         byte_idx, byte_idx_next;
    logic               tx_next, clk_last;
    logic [ENTRY_W-1:0] msg;
    logic [7:0]         id8, cur_byte;
    logic [15:0]        msg_data;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // A push into a full FIFO is still accepted when a pop frees a slot that edge.
    assign fifo_full = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = (state == IDLE) && (count != '0);
    assign push      = output_enable && (!fifo_full || pop);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    assign id8      = 8'(msg[ENTRY_W-1:16]);
    assign msg_data = msg[15:0];
    assign clk_last = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cur_byte = 8'h0A;
        case (byte_idx)
            4'd0:    cur_byte = hex_ascii(id8[7:4]);
            4'd1:    cur_byte = hex_ascii(id8[3:0]);
            4'd2:    cur_byte = 8'h3A;
            4'd3:    cur_byte = hex_ascii(msg_data[15:12]);
            4'd4:    cur_byte = hex_ascii(msg_data[11:8]);
            4'd5:    cur_byte = hex_ascii(msg_data[7:4]);
            4'd6:    cur_byte = hex_ascii(msg_data[3:0]);
            4'd7:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end

    always_comb begin
        state_next    = state;
        clk_cnt_next  = clk_last ? '0 : clk_cnt + CLK_W'(1);
        bit_idx_next  = bit_idx;
        byte_idx_next = byte_idx;
        tx_next       = uart_tx;
        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                tx_next      = 1'b1;
                if (pop) begin
                    state_next    = START;
                    byte_idx_next = '0;
                    bit_idx_next  = '0;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (clk_last) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = cur_byte[0];
                end
            end
            DATA: begin
                if (clk_last) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        tx_next      = cur_byte[bit_idx_next];
                    end
                end
            end
            STOP: begin
                if (clk_last) begin
                    if (byte_idx < 4'd8) begin
                        state_next    = START;
                        byte_idx_next = byte_idx + 4'd1;
                        tx_next       = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {output_core_id, output_data_val};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            uart_tx  <= 1'b1;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            msg      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_idx  <= bit_idx_next;
            byte_idx <= byte_idx_next;
            uart_tx  <= tx_next;
            count    <= count_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                msg    <= mem[rd_ptr];
            end
            overflow <= overflow | (output_enable & ~push);
            busy     <= (state_next != IDLE) || (count_next != '0);
        end
    end

endmodule

// File: doc/output_uart_bridge.md
# output_uart_bridge

Downstream consumer of the cluster top-level output port: captures every `output_enable` strobe (core ID plus 16-bit value) into a small FIFO. It formats each entry as an ASCII line and serialises it on an 8N1 UART transmit pin. The FIFO absorbs single-cycle output bursts from the cores, which arrive far faster than the UART drains them.

## Interface
- `NUM_CORES`, 16: number of cores. The core-ID width is `$clog2(NUM_CORES)` and must be 1..8.
- `FIFO_DEPTH`, 8: entry count. Must be a power of two and ≥2.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit. Must be ≥2.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `output_enable`  in  1  single-cycle strobe; the entry is valid this cycle.
- `output_core_id`  in  $clog2(NUM_CORES)  ID of the writing core.
- `output_data_val`  in  16  value written by the core.
- `uart_tx`  out  1  serial line; idles high.
- `overflow`  out  1  sticky flag: an entry was dropped.
- `busy`  out  1  FIFO non-empty or a message is in flight.

## Operation
- Reset (`reset_n` = 0 at an edge):
  - FIFO emptied; formatter to IDLE.
  - `uart_tx` = 1, `overflow` = 0, `busy` = 0.
- Push: an edge with `output_enable` = 1 stores {core_id, data}.
- Full FIFO:
  - If count == FIFO_DEPTH and no pop at the same edge, the entry is dropped and `overflow` sets.
  - A simultaneous push and pop on a full FIFO is accepted.
- Pop: occurs at any edge where the formatter is IDLE and the FIFO is non-empty. The entry is latched into the message register.
- Message format: 9 bytes, sent in order.
  - Core ID, zero-extended to 8 bits, as 2 hex digits.
  - ':' (0x3A).
  - Data value as 4 hex digits, most significant first.
  - CR (0x0D), LF (0x0A).
  - Hex digits are '0'–'9' (0x30–0x39) and 'A'–'F' (0x41–0x46).
- Formatter states:
  - IDLE → START on pop.
  - START (1 bit time) → DATA.
  - DATA (8 bits, LSB first) → STOP.
  - STOP (1 bit time) → START with the next byte if the byte index < 8, else IDLE.
- Byte index runs 0..8 and resets to 0 on pop.
- UART line levels: start bit 0, data bits as above, stop bit 1. IDLE drives 1.
- `overflow` clears only on reset.
- `busy` = (formatter != IDLE) | (count != 0).

## Timing
- Each bit lasts exactly CLKS_PER_BIT cycles (counter from 0 to CLKS_PER_BIT-1). Each byte lasts 10·CLKS_PER_BIT cycles.
- Pop to start bit: `uart_tx` falls on the edge that performs the pop. The start bit therefore begins 1 cycle after the push edge if the formatter was idle.
- Byte to byte: back-to-back, no gap. The next start bit begins the cycle after the stop bit's last cycle.
- Message length: 90·CLKS_PER_BIT cycles.
- Message to message: if the FIFO is non-empty when STOP of byte 8 completes, the formatter returns to IDLE for that edge. The pop happens the following edge, giving exactly 1 idle-high cycle between messages.
- Capacity: with the formatter idle, FIFO_DEPTH+1 consecutive strobes are accepted. The first is popped immediately; strobe FIFO_DEPTH+2 is dropped.
- `overflow` and `busy` are registered; each updates on the edge of the causing event.
- Reset mid-character:
  - `uart_tx` is 1 from the reset edge onward.
  - The partial message and FIFO contents are discarded.
  - No stop bit is completed.
- `uart_tx` is a registered output with no combinational path from the inputs.

## Test plan
- Single entry, CLKS_PER_BIT=4: core 5, value 0xBEEF.
  - Line decodes "05:BEEF\r\n" (30 35 3A 42 45 45 46 0D 0A).
  - Each bit is 4 cycles; 360 cycles total.
  - `busy` falls on the edge after the last stop bit.
- Boundary digits:
  - Core 0, value 0x0000 → "00:0000\r\n".
  - Core 15, value 0xA9F0 → "0F:A9F0\r\n".
  - Sent back-to-back, with 1 idle cycle between them.
- Burst overflow, FIFO_DEPTH=8: 10 strobes on consecutive cycles, values 1..10.
  - Exactly values 1..9 are transmitted, in order.
  - `overflow` rises on the 10th strobe's edge and stays 1.
- Push during pop on a full FIFO: with count=8 and the formatter finishing byte 8, a strobe on the pop edge is accepted and `overflow` stays 0.
- Reset mid-operation: assert `reset_n` = 0 for 1 cycle during a data bit of byte 3.
  - `uart_tx` = 1 and `busy` = 0 from the next edge.
  - `overflow` = 0.
  - A new strobe after reset produces a clean complete message.
- Idle line: no strobes for 1000 cycles after reset → `uart_tx` held at 1 and `busy` = 0 throughout.
